accel_issue_sched: RTL and testbench

Issue scheduler for the single shared custom accelerator (ADDX unit), instantiated in the execute stage when EnableAccelerator is set. It shares the accelerator between the NrIssuePorts issue lanes using round-robin arbitration. It tracks in-flight transaction IDs in order and drives the extra (fifth) writeback port. On a pipeline flush it discards results that are still outstanding.

---
 rtl/accel_sched_pkg.sv | 25 ++
 rtl/accel_inflight_q.sv | 60 ++++++
 rtl/accel_issue_sched.sv | 130 +++++++++++++
 tb/tb_accel_issue_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_sched_pkg.sv
// Shared types for the ADDX accelerator issue scheduler: opcodes, in-flight queue
// entries and scheduler FSM states.
package accel_sched_pkg;

    // Queue entries carry IDs up to this width; the scheduler uses the low TransIdBits.
    localparam int MAX_TID_W = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ADDC = 2'd2,
        OP_ADDS = 2'd3
    } accel_op_e;

    typedef struct packed {
        logic [MAX_TID_W-1:0] trans_id;
        logic                 killed;
    } inflight_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

endpackage

// File: rtl/accel_inflight_q.sv
// In-order circular queue of accelerator transactions awaiting a response.
// kill_all marks every stored entry so its response is swallowed.
module accel_inflight_q
    import accel_sched_pkg::*;
#(
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  inflight_entry_t push_entry_i,
    input  logic            pop_i,
    input  logic            kill_all_i,
    output inflight_entry_t head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    inflight_entry_t mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (kill_all_i) begin
                for (int i = 0; i < Depth; i++) mem[i].killed <= 1'b1;
            end
            // A fresh push is never killed; it lands after any kill_all above.
            if (do_push) begin
                mem[wr_ptr] <= push_entry_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/accel_issue_sched.sv
// Round-robin issue scheduler sharing one ADDX accelerator between issue lanes;
// tracks in-flight IDs in order and drives a registered writeback port.
module accel_issue_sched
    import accel_sched_pkg::*;
#(
    parameter int NrIssuePorts = 2,
    parameter int TransIdBits  = 3,
    parameter int XLEN         = 64,
    parameter int MaxInflight  = 2,
    parameter int OpWidth      = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flush_i,
    input  logic [NrIssuePorts-1:0]                  issue_valid_i,
    output logic [NrIssuePorts-1:0]                  issue_ready_o,
    input  logic [NrIssuePorts-1:0][OpWidth-1:0]     issue_op_i,
    input  logic [NrIssuePorts-1:0][XLEN-1:0]        issue_rs1_i,
    input  logic [NrIssuePorts-1:0][XLEN-1:0]        issue_rs2_i,
    input  logic [NrIssuePorts-1:0][TransIdBits-1:0] issue_trans_id_i,
    output logic                                     acc_req_valid_o,
    input  logic                                     acc_req_ready_i,
    output logic [OpWidth-1:0]                       acc_req_op_o,
    output logic [XLEN-1:0]                          acc_req_rs1_o,
    output logic [XLEN-1:0]                          acc_req_rs2_o,
    input  logic                                     acc_resp_valid_i,
    input  logic [XLEN-1:0]                          acc_resp_result_i,
    output logic                                     wb_valid_o,
    output logic [TransIdBits-1:0]                   wb_trans_id_o,
    output logic [XLEN-1:0]                          wb_result_o,
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int CntW  = $clog2(MaxInflight + 1);
    localparam int LaneW = (NrIssuePorts > 1) ? $clog2(NrIssuePorts) : 1;

    sched_state_e    state_q, state_d;
    logic [LaneW-1:0] rr_ptr, grant;
    logic            any_valid, acc_en, hs, pop, wb_fire;
    logic [CntW-1:0] q_count, count_next;
    logic            q_full, q_empty;
    inflight_entry_t q_head, push_entry;
    logic            unused_head_bits;

    // First valid lane at or after rr_ptr, searching cyclically.
    always_comb begin
        int idx;
        logic found;
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NrIssuePorts; k++) begin
            idx = (int'(rr_ptr) + k) % NrIssuePorts;
            if (!found && issue_valid_i[idx]) begin
                grant = LaneW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_valid       = |issue_valid_i;
    assign acc_en          = (state_q == RUN) && !flush_i && !q_full;
    assign acc_req_valid_o = acc_en && any_valid;
    assign acc_req_op_o    = issue_op_i[grant];
    assign acc_req_rs1_o   = issue_rs1_i[grant];
    assign acc_req_rs2_o   = issue_rs2_i[grant];
    assign hs              = acc_req_valid_o && acc_req_ready_i;

    always_comb begin
        issue_ready_o        = '0;
        issue_ready_o[grant] = hs;
    end

    always_comb begin
        push_entry                             = '0;
        push_entry.trans_id[TransIdBits-1:0] = issue_trans_id_i[grant];
    end

    // A head popped during flush counts as killed even though its bit is not yet set.
    assign pop     = acc_resp_valid_i && !q_empty;
    assign wb_fire = pop && !q_head.killed && !flush_i;

    accel_inflight_q #(
        .Depth (MaxInflight),
        .CntW  (CntW)
    ) u_inflight_q (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (hs),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_all_i   (flush_i),
        .head_o       (q_head),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    assign count_next       = q_count + CntW'(hs) - CntW'(pop);
    assign unused_head_bits = ^q_head;

    always_comb begin
        state_d = RUN;
        if ((flush_i || state_q == DRAIN) && count_next != '0) state_d = DRAIN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            rr_ptr        <= '0;
            wb_valid_o    <= 1'b0;
            wb_trans_id_o <= '0;
            wb_result_o   <= '0;
            err_o         <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_o <= wb_fire;
            if (hs) rr_ptr <= (grant == LaneW'(NrIssuePorts - 1)) ? '0 : grant + 1'b1;
            if (wb_fire) begin
                wb_trans_id_o <= q_head.trans_id[TransIdBits-1:0];
                wb_result_o   <= acc_resp_result_i;
            end
            if (acc_resp_valid_i && q_empty) err_o <= 1'b1;
        end
    end

    assign busy_o = (q_count != '0) || (state_q == DRAIN);

endmodule

// File: tb/tb_accel_issue_sched.sv
// Directed bench for accel_issue_sched: a queue-based reference model is compared
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_accel_issue_sched;

    localparam int N    = 2;
    localparam int TW   = 3;
    localparam int XL   = 64;
    localparam int MAXI = 2;
    localparam int OW   = 2;

    logic clk = 1'b0;
    logic rst_i, flush_i;
    logic [N-1:0]         issue_valid_i, issue_ready_o;
    logic [N-1:0][OW-1:0] issue_op_i;
    logic [N-1:0][XL-1:0] issue_rs1_i, issue_rs2_i;
    logic [N-1:0][TW-1:0] issue_trans_id_i;
    logic                 acc_req_valid_o, acc_req_ready_i;
    logic [OW-1:0]        acc_req_op_o;
    logic [XL-1:0]        acc_req_rs1_o, acc_req_rs2_o;
    logic                 acc_resp_valid_i;
    logic [XL-1:0]        acc_resp_result_i;
    logic                 wb_valid_o;
    logic [TW-1:0]        wb_trans_id_o;
    logic [XL-1:0]        wb_result_o;
    logic                 busy_o, err_o;

    always #5 clk = ~clk;

    accel_issue_sched #(
        .NrIssuePorts (N), .TransIdBits (TW), .XLEN (XL), .MaxInflight (MAXI), .OpWidth (OW)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .flush_i (flush_i),
        .issue_valid_i (issue_valid_i), .issue_ready_o (issue_ready_o),
        .issue_op_i (issue_op_i), .issue_rs1_i (issue_rs1_i), .issue_rs2_i (issue_rs2_i),
        .issue_trans_id_i (issue_trans_id_i),
        .acc_req_valid_o (acc_req_valid_o), .acc_req_ready_i (acc_req_ready_i),
        .acc_req_op_o (acc_req_op_o), .acc_req_rs1_o (acc_req_rs1_o), .acc_req_rs2_o (acc_req_rs2_o),
        .acc_resp_valid_i (acc_resp_valid_i), .acc_resp_result_i (acc_resp_result_i),
        .wb_valid_o (wb_valid_o), .wb_trans_id_o (wb_trans_id_o), .wb_result_o (wb_result_o),
        .busy_o (busy_o), .err_o (err_o)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0, cyc_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int tid; bit killed; } ment_t;
    ment_t       mq[$];
    int          m_rr = 0;
    bit          m_drain = 0, m_wbv = 0, m_err = 0;
    logic [TW-1:0] m_wbtid = '0;
    logic [XL-1:0] m_wbres = '0;

    function automatic int pick_lane();
        for (int k = 0; k < N; k++)
            if (issue_valid_i[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic bit model_en();
        return !m_drain && !flush_i && (mq.size() < MAXI);
    endfunction

    always @(posedge clk) begin
        int  g;
        bit  hs;
        ment_t h;
        if (rst_i) begin
            mq.delete();
            m_rr = 0; m_drain = 0; m_wbv = 0; m_err = 0; m_wbtid = '0; m_wbres = '0;
        end else begin
            g  = pick_lane();
            hs = model_en() && (g >= 0) && acc_req_ready_i;
            m_wbv = 0;
            if (acc_resp_valid_i) begin
                if (mq.size() == 0) m_err = 1;
                else begin
                    h = mq.pop_front();
                    m_wbv = !h.killed && !flush_i;
                    if (m_wbv) begin
                        m_wbtid = TW'(h.tid);
                        m_wbres = acc_resp_result_i;
                    end
                end
            end
            if (flush_i) foreach (mq[i]) mq[i].killed = 1;
            if (hs) begin
                mq.push_back('{tid: int'(issue_trans_id_i[g]), killed: 0});
                m_rr = (g + 1) % N;
            end
            m_drain = (mq.size() > 0) && (flush_i || m_drain);
        end
    end

    always @(negedge clk) begin
        int g;
        bit rv;
        logic [N-1:0] rdy;
        if (!rst_i) begin
            g   = pick_lane();
            rv  = model_en() && (g >= 0);
            rdy = '0;
            if (rv && acc_req_ready_i) rdy[g] = 1'b1;
            chk("m_issue_ready", 64'(issue_ready_o), 64'(rdy));
            chk("m_req_valid", 64'(acc_req_valid_o), 64'(rv));
            if (rv) begin
                chk("m_req_op", 64'(acc_req_op_o), 64'(issue_op_i[g]));
                chk("m_req_rs1", acc_req_rs1_o, issue_rs1_i[g]);
                chk("m_req_rs2", acc_req_rs2_o, issue_rs2_i[g]);
            end
            chk("m_wb_valid", 64'(wb_valid_o), 64'(m_wbv));
            chk("m_wb_tid", 64'(wb_trans_id_o), 64'(m_wbtid));
            chk("m_wb_result", wb_result_o, m_wbres);
            chk("m_busy", 64'(busy_o), 64'(mq.size() > 0 || m_drain));
            chk("m_err", 64'(err_o), 64'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rs, input logic [N-1:0] v, input int t0, input int t1,
                         input logic rdy, input logic rsp, input logic fl);
        @(posedge clk); #1;
        rst_i         = rs;
        issue_valid_i = v;
        issue_trans_id_i[0] = TW'(t0);
        issue_trans_id_i[1] = TW'(t1);
        for (int p = 0; p < N; p++) begin
            issue_op_i[p]  = OW'(p + 1);
            issue_rs1_i[p] = 64'h1000 + 64'(issue_trans_id_i[p]) + 64'(p * 16);
            issue_rs2_i[p] = 64'h2000 + 64'(issue_trans_id_i[p]) + 64'(p * 16);
        end
        acc_req_ready_i   = rdy;
        acc_resp_valid_i  = rsp;
        acc_resp_result_i = 64'hBEEF_0000 + 64'(cyc_n);
        flush_i           = fl;
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = '0; issue_op_i = '0;
        issue_rs1_i = '0; issue_rs2_i = '0; issue_trans_id_i = '0;
        acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0; acc_resp_result_i = '0;

        drive(1, 2'b00, 0, 0, 0, 0, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 1, 0, 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_wb_valid", 64'(wb_valid_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_req_valid", 64'(acc_req_valid_o), 0);

        // Fairness: both lanes valid, one response per cycle after the first grant
        drive(0, 2'b11, 2, 5, 1, 0, 0); chk("fair_g0", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b11, 2, 5, 1, 1, 0); chk("fair_g1", 64'(issue_ready_o), 64'b10);
        chk("fair_nowb", 64'(wb_valid_o), 0);
        drive(0, 2'b11, 2, 5, 1, 1, 0); chk("fair_g2", 64'(issue_ready_o), 64'b01);
        chk("fair_wb0", 64'(wb_trans_id_o), 2);
        drive(0, 2'b11, 2, 5, 1, 1, 0); chk("fair_g3", 64'(issue_ready_o), 64'b10);
        chk("fair_wb1", 64'(wb_trans_id_o), 5);
        drive(0, 2'b00, 2, 5, 1, 1, 0); chk("fair_wb2", 64'(wb_trans_id_o), 2);
        drive(0, 2'b00, 2, 5, 1, 0, 0); chk("fair_wb3", 64'(wb_trans_id_o), 5);
        chk("fair_idle_busy", 64'(busy_o), 0);

        // Full queue, then push+pop in the same cycle
        drive(0, 2'b01, 3, 0, 1, 0, 0); chk("full_a0", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b01, 4, 0, 1, 0, 0); chk("full_a1", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b01, 6, 0, 1, 0, 0); chk("full_rdy", 64'(issue_ready_o), 0);
        chk("full_reqv", 64'(acc_req_valid_o), 0);
        drive(0, 2'b01, 6, 0, 1, 1, 0); chk("full_rsp_rdy", 64'(issue_ready_o), 0);
        drive(0, 2'b01, 6, 0, 1, 0, 0); chk("full_resume", 64'(issue_ready_o), 64'b01);
        chk("full_wb", 64'(wb_trans_id_o), 3);
        drive(0, 2'b00, 0, 0, 1, 1, 0);
        drive(0, 2'b10, 0, 7, 1, 1, 0); chk("pp_rdy", 64'(issue_ready_o), 64'b10);
        chk("pp_wb_prev", 64'(wb_trans_id_o), 4);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("pp_wb_older", 64'(wb_trans_id_o), 6);
        chk("pp_busy", 64'(busy_o), 1);
        drive(0, 2'b00, 0, 0, 1, 1, 0); chk("pp_wb_gap", 64'(wb_valid_o), 0);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("pp_wb_last", 64'(wb_trans_id_o), 7);
        chk("pp_idle", 64'(busy_o), 0);

        // Flush with two in flight
        drive(0, 2'b01, 1, 0, 1, 0, 0); chk("fl_a0", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b10, 0, 2, 1, 0, 0); chk("fl_a1", 64'(issue_ready_o), 64'b10);
        drive(0, 2'b00, 0, 0, 1, 0, 1); chk("fl_reqv", 64'(acc_req_valid_o), 0);
        drive(0, 2'b01, 5, 0, 1, 1, 0); chk("fl_busy", 64'(busy_o), 1);
        chk("fl_drain_rdy", 64'(issue_ready_o), 0);
        drive(0, 2'b01, 5, 0, 1, 1, 0); chk("fl_drain_rdy2", 64'(issue_ready_o), 0);
        chk("fl_nowb0", 64'(wb_valid_o), 0);
        drive(0, 2'b01, 5, 0, 1, 0, 0); chk("fl_run_rdy", 64'(issue_ready_o), 64'b01);
        chk("fl_nowb1", 64'(wb_valid_o), 0);

        // Flush coinciding with the response of the single in-flight op
        drive(0, 2'b00, 0, 0, 1, 1, 1);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("fr_nowb", 64'(wb_valid_o), 0);
        chk("fr_busy", 64'(busy_o), 0);
        chk("fr_err0", 64'(err_o), 0);
        drive(0, 2'b00, 0, 0, 1, 1, 0);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("stray_err", 64'(err_o), 1);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("stray_sticky", 64'(err_o), 1);

        // Mid-operation reset with two in flight
        drive(0, 2'b01, 1, 0, 1, 0, 0); chk("mr_a0", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b10, 0, 2, 1, 0, 0); chk("mr_a1", 64'(issue_ready_o), 64'b10);
        drive(1, 2'b00, 0, 0, 1, 0, 0);
        drive(0, 2'b00, 0, 0, 1, 0, 0);
        chk("mr_busy", 64'(busy_o), 0);
        chk("mr_err", 64'(err_o), 0);
        chk("mr_wbv", 64'(wb_valid_o), 0);
        chk("mr_wbtid", 64'(wb_trans_id_o), 0);
        chk("mr_wbres", wb_result_o, 0);
        chk("mr_reqv", 64'(acc_req_valid_o), 0);
        drive(0, 2'b11, 3, 4, 1, 0, 0); chk("mr_g0", 64'(issue_ready_o), 64'b01);
        drive(0, 2'b11, 3, 4, 1, 0, 0); chk("mr_g1", 64'(issue_ready_o), 64'b10);
        drive(0, 2'b00, 0, 0, 1, 1, 0);
        drive(0, 2'b00, 0, 0, 1, 1, 0); chk("mr_wb0", 64'(wb_trans_id_o), 3);
        drive(0, 2'b00, 0, 0, 1, 0, 0); chk("mr_wb1", 64'(wb_trans_id_o), 4);
        chk("mr_err_clean", 64'(err_o), 0);
        drive(0, 2'b00, 0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
